button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Multi-channel input conditioner for the push-button inputs that drive gameplay (flap, start, pause, etc.).
- It is the generalised successor to the plain two-flop button synchroniser. Each channel has a configurable-depth synchroniser chain, a consecutive-sample debounce filter, and registered one-cycle press/release pulses.
- It sits between the raw board inputs and the game FSMs, so that one physical press yields exactly one press pulse.

Parameters:
- CHANNELS, 4: number of independent button channels (>=1).
- SYNC_STAGES, 2: flops in each synchroniser chain (>=2).
- DEBOUNCE_CYCLES, 4: consecutive synchronised samples that must disagree with the current level before the level changes (>=1; 1 = no filtering).
- ACTIVE_LOW, 0: 1 = raw inputs are pressed-low; they are inverted before the first synchroniser flop.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- button  input  CHANNELS  raw, asynchronous button inputs.
- level  output  CHANNELS  debounced pressed state (1 = pressed).
- press  output  CHANNELS  one-cycle pulse per channel on a debounced 0->1 transition.
- release  output  CHANNELS  one-cycle pulse per channel on a debounced 1->0 transition.
- any_press  output  1  registered OR of all press bits for the same cycle.

Behaviour:
- Reset (asynchronous, active-high):
  - Every synchroniser flop, debounce counter, level, press, release and any_press goes to 0 immediately, without waiting for a clock edge.
  - 0 in every flop means "released" after polarity correction.
- Polarity: when ACTIVE_LOW=1, the input to the chain is ~button; otherwise it is button.
- Synchroniser:
  - Stage 0 samples the polarity-corrected input; stage i samples stage i-1 on each clk rising edge.
  - synced = last stage.
  - No reset-free flops.
- Debounce counter, per channel:
  - Width is $clog2(DEBOUNCE_CYCLES), minimum 1.
  - If synced == level, the counter clears to 0.
  - If synced != level and counter < DEBOUNCE_CYCLES-1, the counter increments.
  - If synced != level and counter == DEBOUNCE_CYCLES-1, the update fires on that edge: level <= synced and the counter clears.
  - Any single agreeing sample restarts the count. Counting never wraps.
- Pulses:
  - press and release are registered and assert on the same edge as the level update: press <= update & synced, release <= update & ~synced.
  - Each is high for exactly one cycle, then 0.
  - press and release are never both high on one channel.
- any_press is a register updated on the same edge as press: any_press <= OR of the next-cycle press bits. It is therefore coincident with press.
- Latency:
  - A raw change held stable and first sampled at edge k updates level/press at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - With the defaults this is edge k+5.
- Channel independence:
  - Channels share no state.
  - Simultaneous transitions on several channels produce pulses in the same cycle.
- Reset mid-operation:
  - Partial counts are discarded.
  - A button held through reset release is treated as a new press after the full latency.
- Inputs that change faster than DEBOUNCE_CYCLES samples never change level.

Test Plan:
Defaults unless stated otherwise (CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=0).
1. Clean press: reset for 1 cycle, then button=4'b0001 set before edge 1 and held -> level[0]=1, press[0]=1 and any_press=1 after edge 6. press and any_press return to 0 after edge 7; level[0] stays 1; channels 1-3 stay 0.
2. Glitch rejection: button[1]=1 for 3 edges, then 0 -> level[1], press[1] and release[1] remain 0 throughout.
3. Bounce: button[2] sampled 1,0,1,0, then held 1 from edge m -> level[2]/press[2] assert only after edge m+5; exactly one press pulse.
4. Release: after scenario 1, button[0]=0 held from edge r -> release[0]=1 for one cycle and level[0]=0 after edge r+5; press[0] stays 0.
5. Simultaneous: button[0] and button[3] rise on the same cycle -> press=4'b1001 for one cycle; any_press=1 for that cycle only.
6. Reset mid-debounce and polarity:
   - Assert reset between clock edges while a counter is at 2 -> all outputs read 0 before the next edge.
   - With button held through release, press fires 6 edges after reset deasserts.
   - In a separate ACTIVE_LOW=1 instance, button=4'b1111 -> level stays 0; driving button[0]=0 -> press[0] after the standard latency.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner: per-channel synchroniser, consecutive-sample debounce and one-cycle press/release pulses
module button_conditioner #(
   parameter int CHANNELS        = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter bit ACTIVE_LOW      = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] button,
   output logic [CHANNELS-1:0] level,
   output logic [CHANNELS-1:0] press,
   output logic [CHANNELS-1:0] release_pulse,
   output logic                any_press
);
   localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   logic [CHANNELS-1:0]    raw, synced, upd;
   logic [SYNC_STAGES-1:0] chain [CHANNELS];
   logic [CW-1:0]          cnt   [CHANNELS];
   assign raw = ACTIVE_LOW ? ~button : button;
   // a level update fires on the sample that completes a full run of disagreeing samples
   always_comb begin
      synced = '0;
      upd    = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         synced[c] = chain[c][SYNC_STAGES-1];
         upd[c]    = synced[c] != level[c] && cnt[c] == LAST;
      end
   end
   // synchroniser chains and debounce run counters; any agreeing sample restarts the run
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < CHANNELS; c++) begin
            chain[c] <= '0;
            cnt[c]   <= '0;
         end
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            chain[c] <= {chain[c][SYNC_STAGES-2:0], raw[c]};
            cnt[c]   <= (synced[c] == level[c] || upd[c]) ? '0 : cnt[c] + 1'b1;
         end
      end
   end
   // debounced level plus registered pulses, all changing on the update edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level         <= '0;
         press         <= '0;
         release_pulse <= '0;
         any_press     <= 1'b0;
      end else begin
         level         <= level ^ upd;
         press         <= upd & synced;
         release_pulse <= upd & ~synced;
         any_press     <= |(upd & synced);
      end
   end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: table, directed and randomized checks against a sample-history model
module tb_button_conditioner;
   localparam int S = 2;
   localparam int D = 4;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] button = 4'b0000;
   logic [3:0] button_n = 4'b1111;
   logic [3:0] level, press, release_pulse;
   logic       any_press;
   logic [3:0] level_n, press_n, release_n;
   logic       any_n;
   int         passed = 0;
   int         total = 0;
   logic [3:0] hist[$];
   logic [3:0] m_level = '0, m_press = '0, m_rel = '0;
   logic       m_any = 1'b0;

   typedef struct {
      logic [3:0] btn;
      logic [3:0] lvl;
      logic [3:0] prs;
      logic [3:0] rel;
      logic       any;
   } vec_t;
   vec_t tbl[15];

   button_conditioner #(.CHANNELS(4), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(0)) dut (
      .clk(clk), .reset(reset), .button(button), .level(level), .press(press),
      .release_pulse(release_pulse), .any_press(any_press));

   button_conditioner #(.CHANNELS(4), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1)) dut_n (
      .clk(clk), .reset(reset), .button(button_n), .level(level_n), .press(press_n),
      .release_pulse(release_n), .any_press(any_n));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      else passed++;
   endtask

   task automatic model_reset();
      hist.delete();
      m_level = '0; m_press = '0; m_rel = '0; m_any = 1'b0;
   endtask

   // level changes once the last D synchronised samples (raw delayed S edges) all differ from it
   task automatic model_edge(input logic [3:0] b);
      logic [3:0] upd, syn;
      hist.push_back(b);
      if (hist.size() > 32) void'(hist.pop_front());
      upd = '0;
      syn = '0;
      for (int c = 0; c < 4; c++) begin
         logic ok;
         ok = 1'b1;
         for (int j = 0; j < D; j++) begin
            int idx;
            logic v;
            idx = hist.size() - 1 - S - j;
            v = idx >= 0 ? hist[idx][c] : 1'b0;
            if (v == m_level[c]) ok = 1'b0;
            if (j == 0) syn[c] = v;
         end
         upd[c] = ok;
      end
      m_press = upd & syn;
      m_rel   = upd & ~syn;
      m_any   = |m_press;
      m_level = m_level ^ upd;
   endtask

   task automatic step(input logic [3:0] b);
      button = b;
      @(posedge clk);
      model_edge(b);
      @(negedge clk);
      check("model", {level, press, release_pulse, any_press}, {m_level, m_press, m_rel, m_any});
   endtask

   initial begin
      int npress;
      logic [3:0] rb;
      for (int i = 0; i < 15; i++) begin
         tbl[i].btn = i < 8 ? 4'b0001 : 4'b0000;
         tbl[i].lvl = (i >= 5 && i < 13) ? 4'b0001 : 4'b0000;
         tbl[i].prs = i == 5 ? 4'b0001 : 4'b0000;
         tbl[i].rel = i == 13 ? 4'b0001 : 4'b0000;
         tbl[i].any = i == 5;
      end
      #1;
      check("reset_state", {level, press, release_pulse, any_press, level_n, press_n, release_n, any_n}, '0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 15; i++) begin
         step(tbl[i].btn);
         check("table", {level, press, release_pulse, any_press},
               {tbl[i].lvl, tbl[i].prs, tbl[i].rel, tbl[i].any});
         check("active_low_idle", level_n, 4'b0000);
      end
      for (int j = 0; j < 9; j++) begin
         step(j < 3 ? 4'b0010 : 4'b0000);
         check("glitch", {level[1], press[1], release_pulse[1]}, 3'b000);
      end
      step(4'b0100); step(4'b0000); step(4'b0100); step(4'b0000);
      npress = 0;
      for (int j = 0; j < 8; j++) begin
         step(4'b0100);
         if (press[2]) npress++;
         check("bounce_press", press[2], j == 5);
         check("bounce_level", level[2], j >= 5);
      end
      check("bounce_count", npress, 1);
      for (int j = 0; j < 8; j++) step(4'b0000);
      check("bounce_released", level, 4'b0000);
      for (int j = 0; j < 8; j++) begin
         step(4'b1001);
         check("simul_press", {press, any_press}, j == 5 ? 5'b10011 : 5'b00000);
      end
      for (int j = 0; j < 4; j++) step(4'b1011);
      #1 reset = 1'b1;
      #1;
      check("async_reset", {level, press, release_pulse, any_press}, '0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int j = 0; j < 8; j++) begin
         step(4'b1011);
         check("held_through_reset", press, j == 5 ? 4'b1011 : 4'b0000);
      end
      button_n = 4'b1110;
      for (int j = 0; j < 8; j++) begin
         step(4'b1011);
         check("active_low_press", {press_n, release_n}, j == 5 ? 8'h10 : 8'h00);
      end
      check("active_low_level", level_n, 4'b0001);
      reset = 1'b1;
      @(negedge clk);
      model_reset();
      reset = 1'b0;
      rb = 4'b0000;
      for (int j = 0; j < 400; j++) begin
         for (int c = 0; c < 4; c++) if ($urandom_range(0, 4) == 0) rb[c] = ~rb[c];
         step(rb);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
